// File: rtl/serial_full_adder_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
interface serial_full_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/serial_full_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, one
// DIGIT-wide adder plus a carry flop; results land in hold registers on done.
module serial_full_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    serial_full_adder_if.slave  io
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_full_adder: DIGIT must be >=1 and divide WIDTH exactly");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_ff_q, carry_ff_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             carry_q, carry_d, ovf_q, ovf_d;

    logic [DIGIT:0]   dsum;
    logic             msb_cin;
    logic             last;

    always_comb begin
        dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_ff_q};
        // Recover the carry into the top bit of this digit from its sum bit.
        msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
        last    = (cnt_q == CW'(N - 1));

        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        work_d     = work_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        carry_ff_d = carry_ff_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        carry_d    = carry_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    a_d        = io.a;
                    // a - b - cin == a + ~b + !cin
                    b_d        = io.b ^ {WIDTH{io.sub}};
                    carry_ff_d = io.cin ^ io.sub;
                    cnt_d      = '0;
                end
            end
            RUN: begin
                a_d        = a_q >> DIGIT;
                b_d        = b_q >> DIGIT;
                work_d     = work_q >> DIGIT;
                work_d[WIDTH-DIGIT +: DIGIT] = dsum[DIGIT-1:0];
                carry_ff_d = dsum[DIGIT];
                cnt_d      = cnt_q + CW'(1);
                if (last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    sum_d   = work_d;
                    carry_d = dsum[DIGIT];
                    ovf_d   = msb_cin ^ dsum[DIGIT];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            carry_ff_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            work_q     <= work_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            carry_ff_q <= carry_ff_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
        end
    end

    assign io.busy     = busy_q;
    assign io.done     = done_q;
    assign io.sum      = sum_q;
    assign io.carry    = carry_q;
    assign io.overflow = ovf_q;
endmodule

// File: doc/serial_full_adder.md
# serial_full_adder

Parametrised digit-serial adder/subtractor that generalises the single-bit full adder to WIDTH-bit operands. It processes DIGIT bits per clock, LSB digit first, using one DIGIT-wide full-adder chain and a carry flip-flop. Operation is controlled by a start/busy/done handshake. It is the area-lean arithmetic option for datapaths that can tolerate multi-cycle latency. With WIDTH=1, DIGIT=1 it reduces functionally to a registered full adder.

## Interface
- WIDTH, 8, operand and result width in bits; ≥1.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly (elaboration error otherwise).
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in when sub=0, borrow-in when sub=1; captured at start.
- sub  in  1  0: a+b+cin; 1: a−b−cin; captured at start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result outputs updated in the same cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry  out  1  carry-out of MSB; for sub=1, 1 = no borrow and 0 = borrow.
- overflow  out  1  two's-complement overflow, equal to the carry into the MSB XOR the carry out of the MSB.

## Operation
- N = WIDTH/DIGIT digit steps per operation; a digit counter runs over 0..N−1.
- States:
  - IDLE: busy=0. A start sampled high moves to RUN and latches a, b ^ {WIDTH{sub}}, sub, and carry_ff = cin ^ sub. Subtraction is computed as a + ~b + !cin.
  - RUN: busy=1. Each edge adds digit k of the latched operands plus carry_ff, stores the DIGIT result bits into a working register, updates carry_ff, and increments k.
  - The edge that processes k = N−1 returns to IDLE and does three things:
    - copies the working register to sum;
    - copies the final carry to carry;
    - computes overflow from the MSB stage's carry-in and carry-out.
  - done=1 for the cycle that follows that edge.
- sum, carry and overflow are result registers. They hold the last completed result until the next completion and do not toggle during RUN.
- a, b, cin and sub are don't-care after capture. Changing them during RUN has no effect.
- start during RUN is ignored: it is neither queued nor an error.
- start high in the done cycle is accepted, because the state is IDLE. Back-to-back throughput is therefore one result per N+1 cycles.

## Timing
- Reset (rst high at an edge) sets state IDLE, counter 0, carry_ff 0, and busy, done, sum, carry, overflow all 0. rst takes priority over start.
- Reset mid-RUN aborts the operation. No done is produced and the result registers clear to 0.
- Latency: if start is accepted at edge T, busy is high from T through T+N−1, done is high and the results are valid after edge T+N, and busy is low in the done cycle.
- done is never high for two consecutive cycles.
- Wrap-around: the sum is truncated to WIDTH bits, and the carry-out appears only on carry.
- DIGIT=WIDTH gives N=1, which is a registered full-width adder with single-cycle latency.

## Test plan
- WIDTH=1, DIGIT=1, all 8 (a,b,cin) combinations with sub=0:
  - sum and carry match the full-adder truth table (1+1+1 gives sum=1, carry=1);
  - done arrives 1 cycle after start.
- WIDTH=8, DIGIT=1:
  - 8'hFF+8'h01, cin=0: sum=8'h00, carry=1, overflow=0, done exactly 8 cycles after the start edge;
  - 8'h7F+8'h01: sum=8'h80, carry=0, overflow=1.
- WIDTH=8, DIGIT=4, sub=1:
  - 8'h05−8'h07, cin=0: sum=8'hFE, carry=0, overflow=0, done 2 cycles after start;
  - 8'h80−8'h01: sum=8'h7F, carry=1, overflow=1;
  - 8'h10−8'h00 with cin=1: sum=8'h0F.
- start pulsed again at cycle 3 of a DIGIT=1 run, with different operands: ignored. A single done with the first operation's result.
- rst asserted at cycle 4 of a run: busy=0 and all outputs 0 on the next cycle, and no done follows. A new start is then accepted normally.
- Back-to-back: start held high continuously gives done every N+1 cycles, and each result matches the operands captured at its own start.
